// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction fetch front end.
// Owns the fetch PC, drives instruction memory, and buffers fetched words with
// their PC+4 in a small FIFO that feeds IF/ID through a valid/ready handshake.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   imem_addr         fetch address (the fetch_pc register)
//   imem_rdata        combinational instruction memory data for imem_addr
//   redirect_valid/pc taken branch/jump: flush queue and refetch from pc
//   halt_req          stop fetching; the queue drains
//   out_valid/ready   handshake towards IF/ID
//   out_instr         head instruction
//   out_pc_plus4      head fetch address + 4
//   count             queue occupancy
//
// Build option: FETCHQ_BYPASS_EN presents a fetch directly on out_* when the
// queue is empty (zero latency). Without it out_* come only from flops.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned IW       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              imem_addr,
  input  logic [IW-1:0]            imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IW-1:0]            out_instr,
  output logic [31:0]              out_pc_plus4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IW-1:0]    instr_mem_q [DEPTH];
  logic [IW-1:0]    instr_mem_d [DEPTH];
  logic [31:0]      pc4_mem_q [DEPTH];
  logic [31:0]      pc4_mem_d [DEPTH];
  logic             head_valid_q, head_valid_d;
  logic [IW-1:0]    head_instr_q, head_instr_d;
  logic [31:0]      head_pc4_q, head_pc4_d;

  logic             pop;
  logic             push;
  logic             fifo_wr;
  logic             bypass_take;
  logic [31:0]      fetch_pc_plus4;

  // Low redirect bits are dropped: fetch addresses are always word aligned.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

`ifdef FETCHQ_BYPASS_EN
  logic bypass_active;
  assign bypass_active = (count_q == '0) & (state_q == RUN) & ~redirect_valid;
  assign bypass_take   = bypass_active & out_ready;
  // Empty queue in RUN: the live fetch is shown directly on the outputs.
  assign out_valid     = bypass_active | head_valid_q;
  assign out_instr     = bypass_active ? imem_rdata     : head_instr_q;
  assign out_pc_plus4  = bypass_active ? fetch_pc_plus4 : head_pc4_q;
`else
  assign bypass_take   = 1'b0;
  assign out_valid     = head_valid_q;
  assign out_instr     = head_instr_q;
  assign out_pc_plus4  = head_pc4_q;
`endif

  assign imem_addr = fetch_pc_q;
  assign count     = count_q;

  // Next-state logic: FSM, queue pointers, fetch PC and registered head view.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    instr_mem_d    = instr_mem_q;
    pc4_mem_d      = pc4_mem_q;
    head_valid_d   = 1'b0;
    head_instr_d   = '0;
    head_pc4_d     = '0;

    fetch_pc_plus4 = fetch_pc_q + 32'd4;
    pop            = head_valid_q & out_ready;
    // A pop frees a slot in the same cycle, so a full queue still sustains one fetch per cycle.
    push           = (state_q == RUN) & ~redirect_valid & ((count_q < CW'(DEPTH)) | pop);
    fifo_wr        = push & ~bypass_take;

    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt_req) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      // Redirect wins over everything: flush and restart from the aligned target.
      state_d    = RUN;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (fifo_wr) begin
        instr_mem_d[wr_ptr_q] = imem_rdata;
        pc4_mem_d[wr_ptr_q]   = fetch_pc_plus4;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (push) begin
        fetch_pc_d = fetch_pc_plus4;
      end
      count_d = count_q + CW'(fifo_wr) - CW'(pop);
    end

    // Head view reads the post-write array so a push into an empty queue shows next cycle.
    if (count_d != '0) begin
      head_valid_d = 1'b1;
      head_instr_d = instr_mem_d[rd_ptr_d];
      head_pc4_d   = pc4_mem_d[rd_ptr_d];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_instr_q <= '0;
      head_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_instr_q <= head_instr_d;
      head_pc4_q   <= head_pc4_d;
    end
  end

  // Queue storage; stale contents are harmless because count gates visibility.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc4_mem_q   <= pc4_mem_d;
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue contents, fetch PC, and fetch mode flags.
  logic [31:0] mq_i[$];
  logic [31:0] mq_p[$];
  logic [31:0] m_pc;
  bit          m_run;
  bit          m_halt;

  logic        exp_v;
  logic [31:0] exp_i;
  logic [31:0] exp_p;
  logic [2:0]  exp_cnt;
  logic [31:0] exp_addr;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .IW(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc_plus4   (out_pc_plus4),
    .count          (count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Expected outputs for the current model state and inputs.
  task automatic predict();
    exp_cnt  = 3'(mq_i.size());
    exp_addr = m_pc;
    if (mq_i.size() > 0) begin
      exp_v = 1'b1; exp_i = mq_i[0]; exp_p = mq_p[0];
    end else begin
      exp_v = 1'b0; exp_i = '0; exp_p = '0;
    end
`ifdef FETCHQ_BYPASS_EN
    if (mq_i.size() == 0 && m_run && !redirect_valid) begin
      exp_v = 1'b1; exp_i = mem_word(m_pc); exp_p = m_pc + 32'd4;
    end
`endif
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic h, input logic rdy);
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc; halt_req = h; out_ready = rdy;
    #1;
    predict();
  endtask

  // Clock edge plus model update from the inputs held across it.
  task automatic advance();
    bit consumed;
    int size_pre;
    @(posedge clk);
    if (rst) begin
      mq_i.delete(); mq_p.delete();
      m_pc = RESET_PC; m_run = 0; m_halt = 0;
    end else begin
      consumed = exp_v && out_ready;
      size_pre = mq_i.size();
      if (consumed && size_pre > 0) begin
        void'(mq_i.pop_front()); void'(mq_p.pop_front());
      end
      if (redirect_valid) begin
        mq_i.delete(); mq_p.delete();
        m_pc = redirect_pc & ~32'd3; m_run = 1; m_halt = 0;
      end else if (!m_run && !m_halt) begin
        m_run = 1;
      end else if (m_run) begin
        if (consumed && size_pre == 0) begin
          m_pc = m_pc + 32'd4;
        end else if (size_pre < DEPTH || consumed) begin
          mq_i.push_back(mem_word(m_pc));
          mq_p.push_back(m_pc + 32'd4);
          m_pc = m_pc + 32'd4;
        end
        if (halt_req) begin m_run = 0; m_halt = 1; end
      end
    end
  endtask

  task automatic reset_dut();
    drive(1, 0, 0, 0, 0);
    advance();
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 1);
    advance();
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0, 1);
      n_vec++;
      if ({out_valid, out_instr, out_pc_plus4, count, imem_addr} !== {1'b0, 32'h0, 32'h0, 3'd0, RESET_PC}) begin
        n_err++;
        $display("FAIL reset: v=%b i=%h p=%h c=%0d a=%h want all zero / a=%h",
                 out_valid, out_instr, out_pc_plus4, count, imem_addr, RESET_PC);
      end
      advance();
    end
  endtask

  task automatic test_stream();
    reset_dut();
    for (int k = 0; k < 14; k++) begin
      drive(0, 0, 0, 0, 1);
      n_vec++;
      if ({out_valid, out_instr, out_pc_plus4, count, imem_addr} !== {exp_v, exp_i, exp_p, exp_cnt, exp_addr}) begin
        n_err++;
        $display("FAIL stream[%0d]: got v=%b i=%h p=%h c=%0d a=%h want v=%b i=%h p=%h c=%0d a=%h", k,
                 out_valid, out_instr, out_pc_plus4, count, imem_addr, exp_v, exp_i, exp_p, exp_cnt, exp_addr);
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 0, 0, (k >= 8));
      n_vec++;
      if ({out_valid, out_instr, out_pc_plus4, count, imem_addr} !== {exp_v, exp_i, exp_p, exp_cnt, exp_addr}) begin
        n_err++;
        $display("FAIL backpressure[%0d]: got v=%b i=%h p=%h c=%0d a=%h want v=%b i=%h p=%h c=%0d a=%h", k,
                 out_valid, out_instr, out_pc_plus4, count, imem_addr, exp_v, exp_i, exp_p, exp_cnt, exp_addr);
      end
      if (k == 8) begin
        n_vec++;
        if (count !== 3'd4 || imem_addr !== 32'h10 || out_pc_plus4 !== 32'h4) begin
          n_err++;
          $display("FAIL full_hold: c=%0d a=%h p=%h want c=4 a=00000010 p=00000004", count, imem_addr, out_pc_plus4);
        end
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    logic [31:0] first_p;
    bit          seen;
    reset_dut();
    for (int k = 0; k < 10 && mq_i.size() < 3; k++) begin
      drive(0, 0, 0, 0, 0);
      advance();
    end
    drive(0, 1, 32'h43, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0);
    n_vec++;
`ifdef FETCHQ_BYPASS_EN
    if (count !== 3'd0 || imem_addr !== 32'h40 || out_pc_plus4 !== 32'h44) begin
`else
    if (count !== 3'd0 || imem_addr !== 32'h40 || out_valid !== 1'b0) begin
`endif
      n_err++;
      $display("FAIL redirect_flush: c=%0d a=%h v=%b p=%h want c=0 a=00000040", count, imem_addr, out_valid, out_pc_plus4);
    end
    seen = 0; first_p = '0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) drive(0, 0, 0, 0, 1);
      n_vec++;
      if ({out_valid, out_instr, out_pc_plus4, count, imem_addr} !== {exp_v, exp_i, exp_p, exp_cnt, exp_addr}) begin
        n_err++;
        $display("FAIL redirect[%0d]: got v=%b i=%h p=%h c=%0d a=%h want v=%b i=%h p=%h c=%0d a=%h", k,
                 out_valid, out_instr, out_pc_plus4, count, imem_addr, exp_v, exp_i, exp_p, exp_cnt, exp_addr);
      end
      if (out_valid === 1'b1 && !seen) begin seen = 1; first_p = out_pc_plus4; end
      advance();
    end
    n_vec++;
    if (first_p !== 32'h44) begin
      n_err++;
      $display("FAIL redirect_target: first pc_plus4=%h want 00000044", first_p);
    end
  endtask

  task automatic test_halt();
    logic [31:0] frozen_addr;
    logic [2:0]  frozen_cnt;
    reset_dut();
    for (int k = 0; k < 10 && mq_i.size() < 2; k++) begin
      drive(0, 0, 0, 0, 0);
      advance();
    end
    drive(0, 0, 0, 1, 0);
    advance();
    drive(0, 0, 0, 0, 0);
    frozen_addr = imem_addr; frozen_cnt = count;
    advance();
    for (int k = 0; k < 14; k++) begin
      if (k < 4)       drive(0, 0, 0, (k == 1), 0);
      else if (k < 9)  drive(0, 0, 0, 0, 1);
      else             drive(0, (k == 9), 32'h80, 0, 1);
      n_vec++;
      if ({out_valid, out_instr, out_pc_plus4, count, imem_addr} !== {exp_v, exp_i, exp_p, exp_cnt, exp_addr}) begin
        n_err++;
        $display("FAIL halt[%0d]: got v=%b i=%h p=%h c=%0d a=%h want v=%b i=%h p=%h c=%0d a=%h", k,
                 out_valid, out_instr, out_pc_plus4, count, imem_addr, exp_v, exp_i, exp_p, exp_cnt, exp_addr);
      end
      if (k == 3) begin
        n_vec++;
        if (imem_addr !== frozen_addr || count !== frozen_cnt) begin
          n_err++;
          $display("FAIL halt_frozen: a=%h c=%0d want a=%h c=%0d", imem_addr, count, frozen_addr, frozen_cnt);
        end
      end
      if (k == 10) begin
        n_vec++;
        if (imem_addr !== 32'h80 && imem_addr !== 32'h84) begin
          n_err++;
          $display("FAIL halt_resume: a=%h want 00000080 or 00000084", imem_addr);
        end
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    bit seen_zero;
    seen_zero = 0;
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      drive(0, (k == 1), 32'hFFFF_FFFA, 0, 1);
      n_vec++;
      if ({out_valid, out_instr, out_pc_plus4, count, imem_addr} !== {exp_v, exp_i, exp_p, exp_cnt, exp_addr}) begin
        n_err++;
        $display("FAIL wrap[%0d]: got v=%b i=%h p=%h c=%0d a=%h want v=%b i=%h p=%h c=%0d a=%h", k,
                 out_valid, out_instr, out_pc_plus4, count, imem_addr, exp_v, exp_i, exp_p, exp_cnt, exp_addr);
      end
      if (out_valid === 1'b1 && out_pc_plus4 === 32'h0 && out_instr === 32'h5A5A_FFFC) seen_zero = 1;
      advance();
    end
    n_vec++;
    if (!seen_zero) begin
      n_err++;
      $display("FAIL wrap_seen: no output with pc_plus4=00000000 instr=5a5afffc");
    end
  endtask

  task automatic test_reset_full();
    reset_dut();
    for (int k = 0; k < 12 && mq_i.size() < DEPTH; k++) begin
      drive(0, 0, 0, 0, 0);
      advance();
    end
    drive(1, 0, 0, 0, 1);
    advance();
    drive(0, 0, 0, 0, 1);
    n_vec++;
    if ({out_valid, count, imem_addr} !== {1'b0, 3'd0, RESET_PC}) begin
      n_err++;
      $display("FAIL reset_full: v=%b c=%0d a=%h want v=0 c=0 a=%h", out_valid, count, imem_addr, RESET_PC);
    end
    advance();
  endtask

  task automatic test_random();
    logic r, rv, h, rdy;
    reset_dut();
    for (int k = 0; k < 600; k++) begin
      r   = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 14) == 0);
      h   = ($urandom_range(0, 24) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      drive(r, rv, $urandom, h, rdy);
      n_vec++;
      if ({out_valid, out_instr, out_pc_plus4, count, imem_addr} !== {exp_v, exp_i, exp_p, exp_cnt, exp_addr}) begin
        n_err++;
        $display("FAIL random[%0d]: got v=%b i=%h p=%h c=%0d a=%h want v=%b i=%h p=%h c=%0d a=%h", k,
                 out_valid, out_instr, out_pc_plus4, count, imem_addr, exp_v, exp_i, exp_p, exp_cnt, exp_addr);
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; out_ready = 1'b0;
    m_pc = RESET_PC; m_run = 0; m_halt = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
